// File: rtl/push_event_pkg.sv
// -----------------------------------------------------------------------------
// push_event_pkg
// Shared types and constants for the push-button event queue.
//   - fsm_state_t : handshake FSM states (IDLE, ISSUE, WAIT_BUSY, WAIT_IDLE)
//   - NUM_PUSH    : number of push buttons
//   - DATA_W      : width of the byte handed to the UART TX
//   - ASCII_BASE  : offset used when PUSH_ASCII_EN is defined
//   - encode_byte : button index -> transmitted byte
// Configuration macro: PUSH_ASCII_EN (defined: byte = '0'..'3', undefined:
// byte = raw index 8'h00..8'h03).
// -----------------------------------------------------------------------------
package push_event_pkg;

  localparam int NUM_PUSH = 4;
  localparam int DATA_W   = 8;
  localparam int IDX_W    = 2;
  localparam logic [DATA_W-1:0] ASCII_BASE = 8'h30;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_IDLE = 2'd3
  } fsm_state_t;

  function automatic logic [DATA_W-1:0] encode_byte(input logic [IDX_W-1:0] idx);
`ifdef PUSH_ASCII_EN
    return ASCII_BASE + {{(DATA_W-IDX_W){1'b0}}, idx};
`else
    return {{(DATA_W-IDX_W){1'b0}}, idx};
`endif
  endfunction

endpackage

// File: rtl/push_debounce.sv
// -----------------------------------------------------------------------------
// push_debounce
// One active-low button: 2-flop synchronizer, debounce counter, debounced
// state and a registered one-cycle press strobe (debounced 1->0).
// Ports:
//   i_Clk   in  1 - clock
//   i_Rst   in  1 - synchronous active-high reset
//   i_Push  in  1 - raw button, active-low, asynchronous
//   o_Press out 1 - one-cycle strobe on a debounced press
// -----------------------------------------------------------------------------
module push_debounce
  import push_event_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16'd50000,
  parameter int          CNT_W           = 16
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Push,
  output logic o_Press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic [1:0]       r_sync_vld;
  logic             r_state;
  logic             r_state_d;
  logic [CNT_W-1:0] r_cnt;
  logic             r_armed;
  logic             r_press;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_sync_vld <= 2'b00;
      r_state    <= 1'b1;
      r_state_d  <= 1'b1;
      r_cnt      <= '0;
      r_armed    <= 1'b0;
      r_press    <= 1'b0;
    end else begin
      r_sync1    <= i_Push;
      r_sync2    <= r_sync1;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
      r_state_d  <= r_state;
      // Presses only count once the button has been seen released after
      // reset, so a button held through reset never produces an event.
      r_press    <= r_armed & r_state_d & ~r_state;
      if (r_sync_vld[1] && r_sync2 && r_state) begin
        r_armed <= 1'b1;
      end
      // The counter measures how long the input has disagreed with the
      // debounced state; DEBOUNCE_CYCLES consecutive disagreements flip it.
      if (r_sync2 == r_state) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_state <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_Press = r_press;

endmodule

// File: rtl/push_event_queue.sv
// -----------------------------------------------------------------------------
// push_event_queue
// Debounces four active-low buttons, encodes each press into a byte, queues
// the bytes in a small FIFO and hands them to the UART TX over a start/ready
// handshake. Optional macro: PUSH_ASCII_EN (bytes become ASCII '0'..'3').
// Ports:
//   i_Clk     in  1   - clock
//   i_Rst     in  1   - synchronous active-high reset
//   i_Push    in  4   - raw buttons, active-low, asynchronous
//   i_TxReady in  1   - TX idle, can accept a start
//   o_TxStart out 1   - one-cycle start pulse to the TX
//   o_TxData  out 8   - byte to transmit, held until TX goes busy
//   o_Level   out log2(FIFO_DEPTH)+1 - FIFO occupancy
//   o_Ovf     out 1   - sticky: an event was dropped on a full FIFO
// -----------------------------------------------------------------------------
module push_event_queue
  import push_event_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16'd50000,
  parameter int          CNT_W           = 16,
  parameter int          FIFO_DEPTH      = 4
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst,
  input  logic [NUM_PUSH-1:0]           i_Push,
  input  logic                          i_TxReady,
  output logic                          o_TxStart,
  output logic [DATA_W-1:0]             o_TxData,
  output logic [$clog2(FIFO_DEPTH):0]   o_Level,
  output logic                          o_Ovf
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(FIFO_DEPTH);

  logic [NUM_PUSH-1:0] w_press;
  logic [IDX_W-1:0]    w_idx;
  logic                w_any;
  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic                w_push;

  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [PTR_W:0]      r_count;
  logic                r_ovf;
  logic [DATA_W-1:0]   r_tx_data;
  fsm_state_t          r_fsm;

  generate
    for (genvar gi = 0; gi < NUM_PUSH; gi++) begin : g_btn
      push_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_debounce (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_Push  (i_Push[gi]),
        .o_Press (w_press[gi])
      );
    end
  endgenerate

  // Ascending scan: the last hit is the highest index, which wins.
  always_comb begin
    w_idx = '0;
    w_any = 1'b0;
    for (int i = 0; i < NUM_PUSH; i++) begin
      if (w_press[i]) begin
        w_idx = IDX_W'(i);
        w_any = 1'b1;
      end
    end
  end

  assign w_full  = (r_count == FULL_LVL);
  assign w_empty = (r_count == '0);
  assign w_pop   = (r_fsm == ST_IDLE) && !w_empty && i_TxReady;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign w_push  = w_any && (!w_full || w_pop);

  always_ff @(posedge i_Clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= encode_byte(w_idx);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      r_tx_data <= '0;
      r_fsm     <= ST_IDLE;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
        r_tx_data <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_any && w_full && !w_pop) begin
        r_ovf <= 1'b1;
      end
      case (r_fsm)
        ST_IDLE:      if (w_pop) r_fsm <= ST_ISSUE;
        ST_ISSUE:     r_fsm <= ST_WAIT_BUSY;
        ST_WAIT_BUSY: if (!i_TxReady) r_fsm <= ST_WAIT_IDLE;
        ST_WAIT_IDLE: if (i_TxReady) r_fsm <= ST_IDLE;
        default:      r_fsm <= ST_IDLE;
      endcase
    end
  end

  // Masked by reset so an interrupted ISSUE never leaks a start.
  assign o_TxStart = (r_fsm == ST_ISSUE) && !i_Rst;
  assign o_TxData  = r_tx_data;
  assign o_Level   = r_count;
  assign o_Ovf     = r_ovf;

endmodule
